// File: rtl/finite_log_pkg.sv
// Shared GF(2^M) helpers for the discrete-log unit: field polynomials,
// multiply-by-alpha, alpha powers and the search state encoding.
package finite_log_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SEARCH
  } search_state_t;

  // Primitive field polynomial for each supported degree, x^M term included.
  function automatic int bch_polynomial(input int m);
    case (m)
      2:       return 'h7;
      3:       return 'hB;
      4:       return 'h13;
      5:       return 'h25;
      6:       return 'h43;
      7:       return 'h89;
      8:       return 'h11D;
      9:       return 'h211;
      10:      return 'h409;
      11:      return 'h805;
      12:      return 'h1053;
      default: return 'h13;
    endcase
  endfunction

  // Multiply a field element by alpha: shift up, reduce on overflow.
  function automatic int gf_mul1(input int m, input int x);
    int r;
    r = x << 1;
    if (r[m])
      r = r ^ bch_polynomial(m);
    return r;
  endfunction

  // alpha^k in standard basis.
  function automatic int lpow(input int m, input int k);
    int r;
    r = 1;
    for (int j = 0; j < k; j++)
      r = gf_mul1(m, r);
    return r;
  endfunction

  // Column i of the constant-multiplier matrix: c * alpha^i.
  function automatic int gf_scale(input int m, input int c, input int i);
    int r;
    r = c;
    for (int j = 0; j < i; j++)
      r = gf_mul1(m, r);
    return r;
  endfunction

endpackage

// File: rtl/finite_log_if.sv
// Request/result bundle of the discrete-log unit.
interface finite_log_if #(
  parameter int M = 4
);
  logic         start;
  logic [M-1:0] standard_in;
  logic [M-1:0] log_out;
  logic         busy;
  logic         done;
  logic         zero;

  modport master (
    output start, standard_in,
    input  log_out, busy, done, zero
  );

  modport slave (
    input  start, standard_in,
    output log_out, busy, done, zero
  );
endinterface

// File: rtl/finite_log_const_mul.sv
// Multiply a GF(2^M) element by the constant field element C.
// Each set input bit contributes the precomputed column C*alpha^i.
module finite_log_const_mul
  import finite_log_pkg::*;
#(
  parameter int M = 4,
  parameter int C = 1
) (
  input  logic [M-1:0] in_val,
  output logic [M-1:0] out_val
);

  // XOR together the columns selected by the operand bits.
  always_comb begin
    out_val = '0;
    for (int i = 0; i < M; i++)
      if (in_val[i])
        out_val = out_val ^ M'(gf_scale(M, C, i));
  end

endmodule

// File: rtl/finite_log.sv
// Sequential discrete logarithm in GF(2^M): walks alpha^idx upward,
// STEPS candidate exponents per cycle, until it equals the operand.
module finite_log
  import finite_log_pkg::*;
#(
  parameter int M     = 4,
  parameter int STEPS = 1
) (
  input logic        clk,
  input logic        reset,
  finite_log_if.slave bus
);

  localparam int GROUP_ORDER = (1 << M) - 1;

  search_state_t            state;
  logic [M-1:0]             target;
  logic [M-1:0]             cur;
  logic [M-1:0]             idx;
  logic [M-1:0]             log_r;
  logic                     done_r;
  logic                     zero_r;
  logic [STEPS-1:0][M-1:0]  cand;
  logic [M-1:0]             cur_step;
  logic [STEPS-1:0]         hit;
  logic                     any_hit;
  logic [M-1:0]             hit_off;
  logic                     exhausted;

  assign cand[0] = cur;

  for (genvar k = 1; k < STEPS; k++) begin : g_cand
    finite_log_const_mul #(.M(M), .C(lpow(M, k))) u_mul (
      .in_val  (cur),
      .out_val (cand[k])
    );
  end

  finite_log_const_mul #(.M(M), .C(lpow(M, STEPS))) u_step (
    .in_val  (cur),
    .out_val (cur_step)
  );

  // Candidates whose exponent runs past 2^M-2 would alias; mask them.
  for (genvar k = 0; k < STEPS; k++) begin : g_hit
    assign hit[k] = (cand[k] == target) &&
                    (({1'b0, idx} + (M+1)'(k)) < (M+1)'(GROUP_ORDER));
  end

  assign exhausted = ({1'b0, idx} + (M+1)'(STEPS)) >= (M+1)'(GROUP_ORDER);

  // Priority encoder: lowest matching offset wins.
  always_comb begin
    any_hit = 1'b0;
    hit_off = '0;
    for (int k = STEPS - 1; k >= 0; k--) begin
      if (hit[k]) begin
        any_hit = 1'b1;
        hit_off = M'(k);
      end
    end
  end

  // Search control: start/restart, step, and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      done_r <= 1'b0;
      zero_r <= 1'b0;
      log_r  <= '0;
      cur    <= M'(1);
      idx    <= '0;
      target <= '0;
    end else begin
      done_r <= 1'b0;
      if (bus.start) begin
        if (bus.standard_in == '0) begin
          state  <= ST_IDLE;
          done_r <= 1'b1;
          zero_r <= 1'b1;
          log_r  <= '1;
        end else begin
          target <= bus.standard_in;
          cur    <= M'(1);
          idx    <= '0;
          zero_r <= 1'b0;
          state  <= ST_SEARCH;
        end
      end else if (state == ST_SEARCH) begin
        if (any_hit) begin
          log_r  <= idx + hit_off;
          done_r <= 1'b1;
          state  <= ST_IDLE;
        end else if (exhausted) begin
          log_r  <= '1;
          zero_r <= 1'b1;
          done_r <= 1'b1;
          state  <= ST_IDLE;
        end else begin
          cur <= cur_step;
          idx <= idx + M'(STEPS);
        end
      end
    end
  end

  assign bus.busy    = (state == ST_SEARCH);
  assign bus.done    = done_r;
  assign bus.zero    = zero_r;
  assign bus.log_out = log_r;

endmodule

// File: tb/tb_finite_log.sv
// Bench for finite_log: several field/step configurations side by side,
// a vector table, hand-written restart/reset sequences, exhaustive sweeps
// with back-to-back starts, and random operands against a log-table model.
module tb_finite_log;

  localparam int NCFG    = 7;
  localparam int TIMEOUT = 600;

  logic clk = 1'b0;
  logic reset;

  logic       start_v [NCFG];
  logic [7:0] in_v    [NCFG];
  logic [7:0] log_v   [NCFG];
  logic       busy_v  [NCFG];
  logic       done_v  [NCFG];
  logic       zero_v  [NCFG];

  int total = 0;
  int bad   = 0;
  int pow4 [15];
  int pow8 [255];

  typedef struct {
    int cfg;
    int x;
    int exp_log;
    int exp_zero;
    int exp_lat;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  function automatic int cfg_m(input int c);
    return (c < 4) ? 4 : 8;
  endfunction

  function automatic int cfg_s(input int c);
    case (c)
      0:       return 1;
      1:       return 4;
      2:       return 3;
      3:       return 7;
      4:       return 1;
      5:       return 3;
      default: return 7;
    endcase
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int CM = cfg_m(g);
    localparam int CS = cfg_s(g);
    finite_log_if #(.M(CM)) bus ();
    assign bus.start       = start_v[g];
    assign bus.standard_in = in_v[g][CM-1:0];
    assign log_v[g]        = 8'(bus.log_out);
    assign busy_v[g]       = bus.busy;
    assign done_v[g]       = bus.done;
    assign zero_v[g]       = bus.zero;
    finite_log #(.M(CM), .STEPS(CS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  function automatic int pow_of(input int m, input int l);
    return (m == 4) ? pow4[l] : pow8[l];
  endfunction

  // Reference: logarithm by table lookup over all powers of alpha.
  function automatic int ref_log(input int m, input int x);
    if (x == 0)
      return (1 << m) - 1;
    for (int l = 0; l < (1 << m) - 1; l++)
      if (pow_of(m, l) == x)
        return l;
    return -1;
  endfunction

  function automatic int ref_lat(input int m, input int s, input int x);
    return (x == 0) ? 0 : ref_log(m, x) / s + 1;
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Launch one search and wait for done; b2b issues start inside the done cycle.
  task automatic applyStimulus(input int c, input int x, input bit b2b,
                               output int lat, output int lg, output int zr,
                               output int busy_ok);
    if (!b2b)
      @(negedge clk);
    in_v[c]    = 8'(x);
    start_v[c] = 1'b1;
    @(posedge clk);
    #1;
    start_v[c] = 1'b0;
    lat     = 0;
    busy_ok = 1;
    while (done_v[c] !== 1'b1 && lat < TIMEOUT) begin
      if (busy_v[c] !== 1'b1)
        busy_ok = 0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy_v[c] !== 1'b0)
      busy_ok = 0;
    if (lat >= TIMEOUT)
      lat = -1;
    lg = int'(log_v[c]);
    zr = int'(zero_v[c]);
  endtask

  initial begin
    int v, lat, lg, zr, bok, dcount, m, s, n, c, x;

    for (int i = 0; i < NCFG; i++) begin
      start_v[i] = 1'b0;
      in_v[i]    = '0;
    end

    v = 1;
    for (int l = 0; l < 15; l++) begin
      pow4[l] = v;
      v = v << 1;
      if ((v & 'h10) != 0) v = v ^ 'h13;
    end
    v = 1;
    for (int l = 0; l < 255; l++) begin
      pow8[l] = v;
      v = v << 1;
      if ((v & 'h100) != 0) v = v ^ 'h11D;
    end

    vecs[0]  = '{0, 'h03,   4, 0, 5};
    vecs[1]  = '{1, 'h09,  14, 0, 4};
    vecs[2]  = '{1, 'h01,   0, 0, 1};
    vecs[3]  = '{0, 'h00,  15, 1, 0};
    vecs[4]  = '{2, 'h08,   3, 0, 2};
    vecs[5]  = '{3, 'h09,  14, 0, 3};
    vecs[6]  = '{4, 'h02,   1, 0, 2};
    vecs[7]  = '{5, 'h00, 255, 1, 0};
    vecs[8]  = '{6, 'h01,   0, 0, 1};
    vecs[9]  = '{5, 'h1D,   8, 0, 3};
    vecs[10] = '{0, 'h02,   1, 0, 2};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NCFG; i += 4) begin
      checkOutput($sformatf("rst c%0d log", i),  int'(log_v[i]),  0);
      checkOutput($sformatf("rst c%0d busy", i), int'(busy_v[i]), 0);
      checkOutput($sformatf("rst c%0d done", i), int'(done_v[i]), 0);
      checkOutput($sformatf("rst c%0d zero", i), int'(zero_v[i]), 0);
    end
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].cfg, vecs[i].x, 1'b0, lat, lg, zr, bok);
      checkOutput($sformatf("vec%0d log", i),  lg,  vecs[i].exp_log);
      checkOutput($sformatf("vec%0d zero", i), zr,  vecs[i].exp_zero);
      checkOutput($sformatf("vec%0d lat", i),  lat, vecs[i].exp_lat);
      checkOutput($sformatf("vec%0d busy", i), bok, 1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d pulse", i), int'(done_v[vecs[i].cfg]), 0);
      checkOutput($sformatf("vec%0d hold", i),  int'(log_v[vecs[i].cfg]),  vecs[i].exp_log);
    end

    $display("[TB] restart mid-search");
    @(negedge clk);
    in_v[0] = 8'h09;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    dcount = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done_v[0] === 1'b1) dcount++;
    end
    @(negedge clk);
    in_v[0] = 8'h02;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    if (done_v[0] === 1'b1) dcount++;
    checkOutput("restart busy", int'(busy_v[0]), 1);
    @(posedge clk);
    #1;
    if (done_v[0] === 1'b1) dcount++;
    checkOutput("restart no early done", dcount, 0);
    @(posedge clk);
    #1;
    checkOutput("restart done", int'(done_v[0]), 1);
    checkOutput("restart log", int'(log_v[0]), 1);

    $display("[TB] reset with start");
    @(negedge clk);
    reset = 1'b1;
    in_v[0] = 8'h03;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst+start busy", int'(busy_v[0]), 0);
    checkOutput("rst+start done", int'(done_v[0]), 0);
    checkOutput("rst+start log",  int'(log_v[0]),  0);
    @(negedge clk);
    reset = 1'b0;
    start_v[0] = 1'b0;
    dcount = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) dcount++;
    end
    checkOutput("rst+start quiet", dcount, 0);

    $display("[TB] reset mid-search");
    applyStimulus(0, 'h03, 1'b0, lat, lg, zr, bok);
    checkOutput("pre-rst log", lg, 4);
    @(negedge clk);
    in_v[0] = 8'h09;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst busy", int'(busy_v[0]), 0);
    checkOutput("midrst done", int'(done_v[0]), 0);
    checkOutput("midrst log",  int'(log_v[0]),  0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done_v[0] === 1'b1) dcount++;
    end
    checkOutput("midrst no done", dcount, 0);

    $display("[TB] exhaustive sweeps");
    for (int cc = 0; cc < NCFG; cc++) begin
      if (cc != 1) begin
        m = cfg_m(cc);
        s = cfg_s(cc);
        n = (1 << m) - 1;
        for (int l = 0; l < n; l++) begin
          applyStimulus(cc, pow_of(m, l), l > 0, lat, lg, zr, bok);
          checkOutput($sformatf("sweep c%0d L%0d log", cc, l),  lg,  l);
          checkOutput($sformatf("sweep c%0d L%0d lat", cc, l),  lat, l / s + 1);
          checkOutput($sformatf("sweep c%0d L%0d busy", cc, l), bok, 1);
          if (lat < 0) break;
        end
      end
    end

    $display("[TB] random operands");
    for (int t = 0; t < 60; t++) begin
      c = $urandom_range(0, NCFG - 1);
      m = cfg_m(c);
      s = cfg_s(c);
      x = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, (1 << m) - 1);
      applyStimulus(c, x, 1'b0, lat, lg, zr, bok);
      checkOutput($sformatf("rand%0d c%0d x%0d log", t, c, x),  lg,  ref_log(m, x));
      checkOutput($sformatf("rand%0d c%0d x%0d zero", t, c, x), zr,  (x == 0) ? 1 : 0);
      checkOutput($sformatf("rand%0d c%0d x%0d lat", t, c, x),  lat, ref_lat(m, s, x));
      checkOutput($sformatf("rand%0d c%0d x%0d busy", t, c, x), bok, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
